// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the digit-serial adder: FSM states, default
// operand geometry and a helper sizing the digit counter.
package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH   = 128;
  localparam int DEF_DIGIT_W = 8;
  localparam int DEF_N       = DEF_WIDTH / DEF_DIGIT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n digits; a single-digit adder still gets one bit so
  // the counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result handshake bundle between a client and the serial adder.
// The master issues operands and consumes results; the slave is the adder.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = serial_adder_ctrl_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/serial_adder_ctrl_digit_adder.sv
// One digit of the serial adder: a DIGIT_W-bit ripple of full adders, each
// full adder made of two half adders and an OR. Purely combinational.

module Half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module digit_adder #(
  parameter int DIGIT_W = 8
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  // carry[i] is the carry into bit i of the digit.
  logic [DIGIT_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    logic s1;
    logic c1;
    logic c2;

    Half_adder u_ha0 (.a(a[i]), .b(b[i]),     .s(s1),     .c(c1));
    Half_adder u_ha1 (.a(s1),   .b(carry[i]), .s(sum[i]), .c(c2));

    assign carry[i+1] = c1 | c2;
  end

  assign cout  = carry[DIGIT_W];
  // Carry into the top bit; on the last digit this feeds signed overflow.
  assign c_msb = carry[DIGIT_W-1];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Digit-serial adder/subtractor controller. Operands are latched on accept,
// then one DIGIT_W-bit digit is added per cycle from least to most
// significant; the result is held in DONE until the consumer takes it.
// WIDTH must be a multiple of DIGIT_W.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [CNT_W-1:0] cnt;

  logic               in_ready_c;
  logic               accept;
  logic               last_digit;
  logic [DIGIT_W-1:0] digit_a;
  logic [DIGIT_W-1:0] digit_b;
  logic [DIGIT_W-1:0] digit_sum;
  logic               digit_cout;
  logic               digit_c_msb;

  assign last_digit = (cnt == LAST_DIGIT);
  assign digit_a    = a_reg[int'(cnt) * DIGIT_W +: DIGIT_W];
  assign digit_b    = b_reg[int'(cnt) * DIGIT_W +: DIGIT_W];

  digit_adder #(.DIGIT_W(DIGIT_W)) u_digit_adder (
    .a     (digit_a),
    .b     (digit_b),
    .cin   (carry_reg),
    .sum   (digit_sum),
    .cout  (digit_cout),
    .c_msb (digit_c_msb)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and ready; DONE with out_ready can accept the next request.
  always_comb begin
    next_state = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_digit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          in_ready_c = 1'b1;
          next_state = bus.in_valid ? RUN : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    accept = in_ready_c & bus.in_valid;
  end

  // Operand capture on accept, then one digit per RUN cycle; the counter
  // holds at the last digit so it never wraps inside an operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.sub ? ~bus.b : bus.b;
      carry_reg <= bus.sub ? 1'b1 : bus.cin;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt       <= '0;
    end else if (state == RUN) begin
      sum_reg[int'(cnt) * DIGIT_W +: DIGIT_W] <= digit_sum;
      carry_reg <= digit_cout;
      if (last_digit) begin
        cout_reg <= digit_cout;
        ovf_reg  <= digit_c_msb ^ digit_cout;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl. Expected results are pushed to
// a scoreboard queue when a request is driven and popped when the adder
// presents a result. Inputs change and outputs are sampled on falling edges.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int W     = DEF_WIDTH;
  localparam int DW    = DEF_DIGIT_W;
  localparam int N     = DEF_N;
  localparam int LIMIT = 4 * N;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W), .DIGIT_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference result built from a wide integer sum; overflow from operand
  // and result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
  endtask

  // Called on a falling edge while the adder is ready; returns on the
  // falling edge right after the accept edge.
  task automatic accept_one(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
    drive_req(a, b, cin, sub);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Falling edges elapsed until out_valid, starting from the falling edge
  // after the accept edge; saturates at LIMIT.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop_expected(output exp_t e, output bit empty);
    empty = (sb.size() == 0);
    e     = '0;
    if (!empty) e = sb.pop_front();
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int   cyc;
    exp_t e;
    bit   empty;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.sum !== '0) begin errors++; $display("[TB] FAIL reset_sum: got %h want 0", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout: got %b want 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b want 0", bus.ovf); end
    // Release and request together: the first rising edge must accept.
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(exp_t'{sum: W'(3), cout: 1'b0, ovf: 1'b0});
    accept_one(W'(1), W'(2), 1'b0, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL first_accept_busy: got %b want 1", bus.busy); end
    wait_result(cyc);
    pop_expected(e, empty);
    checks++; if (empty || bus.sum !== e.sum) begin errors++; $display("[TB] FAIL first_accept_sum: got %h want %h (queue empty %b)", bus.sum, e.sum, empty); end
    release_result();
  endtask

  task automatic test_directed_vectors();
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic         vsub[3];
    exp_t         vexp[3];
    exp_t         e;
    bit           empty;
    int           cyc;
    va[0] = W'(1);                  vb[0] = '1;    vsub[0] = 1'b0;
    vexp[0] = exp_t'{sum: '0, cout: 1'b1, ovf: 1'b0};
    va[1] = {1'b0, {(W-1){1'b1}}};  vb[1] = W'(1); vsub[1] = 1'b0;
    vexp[1] = exp_t'{sum: {1'b1, {(W-1){1'b0}}}, cout: 1'b0, ovf: 1'b1};
    va[2] = W'(5);                  vb[2] = W'(7); vsub[2] = 1'b1;
    vexp[2] = exp_t'{sum: {{(W-1){1'b1}}, 1'b0}, cout: 1'b0, ovf: 1'b0};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(vexp[i]);
      accept_one(va[i], vb[i], 1'b0, vsub[i]);
      wait_result(cyc);
      checks++; if (cyc !== N) begin errors++; $display("[TB] FAIL vec%0d_latency: got %0d cycles want %0d", i, cyc, N); end
      pop_expected(e, empty);
      checks++; if (empty || bus.sum !== e.sum) begin errors++; $display("[TB] FAIL vec%0d_sum: got %h want %h", i, bus.sum, e.sum); end
      checks++; if (bus.cout !== e.cout) begin errors++; $display("[TB] FAIL vec%0d_cout: got %b want %b", i, bus.cout, e.cout); end
      checks++; if (bus.ovf !== e.ovf) begin errors++; $display("[TB] FAIL vec%0d_ovf: got %b want %b", i, bus.ovf, e.ovf); end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rcin;
    logic         rsub;
    exp_t         e;
    bit           empty;
    int           cyc;
    for (int i = 0; i < 6; i++) begin
      ra   = rand_word();
      rb   = (i == 5) ? ra : rand_word();
      rcin = 1'($urandom_range(0, 1));
      rsub = (i % 2 == 1);
      sb.push_back(model(ra, rb, rcin, rsub));
      accept_one(ra, rb, rcin, rsub);
      wait_result(cyc);
      checks++; if (cyc !== N) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", i, cyc, N); end
      pop_expected(e, empty);
      checks++; if (empty || bus.sum !== e.sum) begin errors++; $display("[TB] FAIL rand%0d_sum: got %h want %h", i, bus.sum, e.sum); end
      checks++; if (bus.cout !== e.cout) begin errors++; $display("[TB] FAIL rand%0d_cout: got %b want %b", i, bus.cout, e.cout); end
      checks++; if (bus.ovf !== e.ovf) begin errors++; $display("[TB] FAIL rand%0d_ovf: got %b want %b", i, bus.ovf, e.ovf); end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   empty;
    int   cyc;
    bus.out_ready = 1'b1;
    sb.push_back(exp_t'{sum: W'(7), cout: 1'b0, ovf: 1'b0});
    sb.push_back(exp_t'{sum: W'(30), cout: 1'b0, ovf: 1'b0});
    drive_req(W'(3), W'(4), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    // Next operands appear while RUN is busy and must not disturb it.
    drive_req(W'(10), W'(20), 1'b0, 1'b0);
    wait_result(cyc);
    checks++; if (cyc !== N) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d want %0d", cyc, N); end
    pop_expected(e, empty);
    checks++; if (empty || bus.sum !== e.sum) begin errors++; $display("[TB] FAIL b2b_first_sum: got %h want %h", bus.sum, e.sum); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_reaccept: out_valid %b busy %b want 0 1", bus.out_valid, bus.busy); end
    wait_result(cyc);
    checks++; if (cyc + 1 !== N + 1) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles want %0d", cyc + 1, N + 1); end
    bus.in_valid = 1'b0;
    pop_expected(e, empty);
    checks++; if (empty || bus.sum !== e.sum) begin errors++; $display("[TB] FAIL b2b_second_sum: got %h want %h", bus.sum, e.sum); end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: busy %b out_valid %b want 0 0", bus.busy, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    exp_t         e;
    bit           empty;
    int           cyc;
    pa = {4{32'h89AB_CDEF}};
    pb = {4{32'hF000_0001}};
    sb.push_back(model(pa, pb, 1'b1, 1'b0));
    accept_one(pa, pb, 1'b1, 1'b0);
    wait_result(cyc);
    pop_expected(e, empty);
    checks++; if (cyc !== N) begin errors++; $display("[TB] FAIL hold_latency: got %0d want %0d", cyc, N); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || empty || bus.sum !== e.sum || bus.cout !== e.cout || bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: out_valid %b sum %h cout %b in_ready %b want 1 %h %b 0",
                 i, bus.out_valid, bus.sum, bus.cout, bus.in_ready, e.sum, e.cout);
      end
      @(negedge clk);
    end
    release_result();
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_idle: busy %b out_valid %b want 0 0", bus.busy, bus.out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    sb.push_back(model({4{32'h1111_1111}}, {4{32'h2222_2222}}, 1'b0, 1'b0));
    accept_one({4{32'h1111_1111}}, {4{32'h2222_2222}}, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.sum === '0) begin errors++; $display("[TB] FAIL midrun_pre: busy %b sum %h want 1 nonzero", bus.busy, bus.sum); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: in_ready %b out_valid %b busy %b sum %h cout %b ovf %b want 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout, bus.ovf);
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midrun_no_result: out_valid seen %0d cycles want 0", seen); end
  endtask

  initial begin
    $display("[TB] serial_adder_ctrl WIDTH=%0d DIGIT_W=%0d", W, DW);
    test_reset();
    test_directed_vectors();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 128, SHALL set the operand and result width in bits.
REQ-002 Parameter DIGIT_W, default 8, SHALL set the bits added per cycle; WIDTH mod DIGIT_W = 0 is required, and N = WIDTH/DIGIT_W.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  1 = A-B (B inverted, carry-in forced 1)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  final carry-out
- ovf  out  1  signed overflow
- busy  out  1  state != IDLE

Function
REQ-005 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-006 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; otherwise it SHALL be 0.
REQ-007 On accept (in_valid & in_ready) the block SHALL:
- latch a, and latch b (or ~b if sub=1)
- set the carry register to cin (or 1 if sub=1)
- clear the digit counter
- enter RUN.
REQ-008 In RUN, each cycle SHALL add digit k of A, digit k of B and the carry register through one DIGIT_W-bit ripple adder, write the result into digit k of sum, update the carry register, and increment k.
REQ-009 After digit N-1 the block SHALL enter DONE; out_valid SHALL rise exactly N cycles after the accept edge (16 at defaults).
REQ-010 In DONE, sum, cout and ovf SHALL hold stable until out_valid & out_ready.
REQ-011 On DONE with out_ready=1 the block SHALL enter RUN if in_valid=1 (back-to-back accept, same edge), else IDLE.
REQ-012 cout SHALL equal the carry out of bit WIDTH-1.
REQ-013 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-014 For sub=1, cout=1 SHALL mean no borrow (A >= B unsigned).
REQ-015 in_valid during RUN SHALL be ignored; inputs SHALL be sampled only on accept.
REQ-016 out_ready SHALL be ignored outside DONE.
REQ-017 The digit counter SHALL be ceil(log2(N)) bits wide and SHALL not wrap within an operation.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-019 Reset assertion SHALL immediately force:
- state to IDLE
- in_ready=1
- out_valid=0
- busy=0
- sum=0, cout=0, ovf=0
- counter and carry register to 0.
REQ-020 Reset during RUN or DONE SHALL discard the operation; no result SHALL be produced after release.
REQ-021 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, the WIDTH and DIGIT_W defaults, and the derived N.
REQ-023 The per-digit adder SHALL be one sub-module, digit_adder (DIGIT_W-bit ripple of full adders, each built from two Half_adder instances plus an OR).
REQ-024 The controller SHALL contain all FSM, counter and register logic; digit_adder SHALL be purely combinational.

Verification
REQ-025 a=1, b=0xFFFF...F (128-bit), cin=0, sub=0 -> after 16 cycles: sum=0, cout=1, ovf=0.
REQ-026 a=0x7FFF...F, b=1, sub=0 -> sum=0x8000...0, cout=0, ovf=1.
REQ-027 a=5, b=7, sub=1 -> sum=0xFFFF...FE, cout=0 (borrow), ovf=0.
REQ-028 Back-to-back: hold in_valid=1 and out_ready=1 with a=3/b=4, then a=10/b=20 -> sum=7 then sum=30; the second accept occurs on the DONE edge, and results are 17 cycles apart.
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stay stable and in_ready stays 0; release -> IDLE.
REQ-030 Assert rst_n=0 at RUN cycle 7 -> all outputs go to reset values immediately, and no out_valid follows release.
